// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port synchronous memory between the CPU and a debug/loader port.
// Define ARB_STARVE_GUARD_EN to let a starved debug requester win after MAX_WAIT denied IDLE cycles.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_wr,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t                state_q;
    logic                  owner_q, wr_q, cpu_ack_q, dbg_ack_q, mem_rd_q, mem_wr_q, busy_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  dbg_win, win_wr;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    assign dbg_win = dbg_req && (!cpu_req || wait_cnt_q >= 4'(MAX_WAIT));
    always_comb
        wait_cnt_d = (state_q != IDLE) ? wait_cnt_q :
                     (!dbg_req || dbg_win) ? 4'd0 :
                     (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
    always_ff @(posedge clk)
        wait_cnt_q <= rst ? 4'd0 : wait_cnt_d;
`else
    assign dbg_win = dbg_req && !cpu_req;
`endif

    assign win_wr = dbg_win ? dbg_wr : cpu_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            case (state_q)
                IDLE: if (cpu_req || dbg_req) begin
                    // The winner is latched here; later input changes cannot disturb the access.
                    owner_q     <= dbg_win;
                    wr_q        <= win_wr;
                    mem_addr_q  <= dbg_win ? dbg_addr : cpu_addr;
                    mem_wdata_q <= dbg_win ? dbg_wdata : cpu_wdata;
                    mem_rd_q    <= !win_wr;
                    mem_wr_q    <= win_wr;
                    busy_q      <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    cpu_ack_q <= !owner_q;
                    dbg_ack_q <= owner_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory read data arrives in RESP, so it is steered straight through to the owner.
    assign cpu_rdata = (cpu_ack_q && !wr_q) ? mem_rdata : '0;
    assign dbg_rdata = (dbg_ack_q && !wr_q) ? mem_rdata : '0;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural memory model.
module tb_mem_port_arbiter;
    logic       clk = 0, rst = 1;
    logic       cpu_req = 0, cpu_wr = 0, dbg_req = 0, dbg_wr = 0;
    logic [4:0] cpu_addr = 0, dbg_addr = 0, mem_addr;
    logic [7:0] cpu_wdata = 0, dbg_wdata = 0, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata = 0;
    logic       cpu_ack, dbg_ack, mem_rd, mem_wr, busy;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic wr; logic [4:0] addr; logic [7:0] wdata; logic [7:0] rdata;} exp_t;
    exp_t       exp_cpu[$], exp_dbg[$];
    logic [7:0] tb_mem[32], ref_mem[32];
    int         ncmp = 0, nfail = 0, cyc = 0, cpu_n = 0, dbg_n = 0;
    logic       s_vld = 0, s_wr = 0;
    logic [4:0] s_addr = 0;
    logic [7:0] s_wdata = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every ack is matched against the oldest expectation for that port.
    initial forever begin
        exp_t e;
        logic [7:0] rd;
        @(negedge clk);
        if (rst) s_vld = 0;
        else begin
            if (cpu_ack || dbg_ack) begin
                chk(!(cpu_ack && dbg_ack), "both_ack", {cpu_ack, dbg_ack}, 0);
                chk(s_vld && !mem_rd && !mem_wr && busy, "ack_timing", {s_vld, mem_rd, mem_wr, busy}, 4'b1001);
                rd = cpu_ack ? cpu_rdata : dbg_rdata;
                if (cpu_ack) cpu_n++;
                else dbg_n++;
                if (cpu_ack ? exp_cpu.size() == 0 : exp_dbg.size() == 0)
                    chk(0, cpu_ack ? "unexpected_cpu_ack" : "unexpected_dbg_ack", {s_addr, rd}, 0);
                else begin
                    if (cpu_ack) e = exp_cpu.pop_front();
                    else e = exp_dbg.pop_front();
                    chk({s_wr, s_addr, s_wdata, rd} == e, cpu_ack ? "cpu_xfer" : "dbg_xfer",
                        {s_wr, s_addr, s_wdata, rd}, e);
                end
            end
            s_vld = mem_rd || mem_wr;
            if (s_vld) begin
                chk(!(mem_rd && mem_wr), "one_strobe", {mem_rd, mem_wr}, 0);
                s_wr = mem_wr;
                s_addr = mem_addr;
                s_wdata = mem_wdata;
            end
        end
    end

    task automatic access(input bit dbg, input bit wr, input logic [4:0] addr, input logic [7:0] wd,
                          output int t_ack, output int waits);
        exp_t e;
        e.wr = wr;
        e.addr = addr;
        e.wdata = wd;
        e.rdata = wr ? 8'h00 : ref_mem[addr];
        if (wr) ref_mem[addr] = wd;
        if (dbg) exp_dbg.push_back(e);
        else exp_cpu.push_back(e);
        @(negedge clk);
        if (dbg) begin dbg_req = 1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wd; end
        else begin cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd; end
        t_ack = -1;
        waits = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (dbg ? dbg_ack : cpu_ack) begin
                waits = i;
                t_ack = cyc;
                break;
            end
        end
        if (dbg) dbg_req = 0;
        else cpu_req = 0;
        chk(t_ack >= 0, dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", waits, 60);
    endtask

    initial begin
        int ta, tb, wa, wb, kc, kd_at, cyc_d, cpu_after;
        bit cpu_on, dbg_on;
        exp_t ec, ed;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[3] = 8'hA5;
        ref_mem[3] = 8'hA5;
        repeat (2) @(negedge clk);
        chk({cpu_ack, dbg_ack, mem_rd, mem_wr, busy, mem_addr, mem_wdata, cpu_rdata, dbg_rdata} == 0,
            "reset_state", {cpu_ack, dbg_ack, mem_rd, mem_wr, busy, mem_addr}, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // CPU read: strobe one cycle after sampling, ack the cycle after that
        access(0, 0, 5'h03, 8'h11, ta, wa);
        chk(wa == 2, "cpu_read_latency", wa, 2);
        // Debug write then CPU read-back
        access(1, 1, 5'h1F, 8'h3C, ta, wa);
        chk(wa == 2, "dbg_write_latency", wa, 2);
        access(0, 0, 5'h1F, 8'h00, ta, wa);

        // Simultaneous requests: CPU first, debug on the next IDLE
        fork
            access(0, 0, 5'h05, 8'h22, ta, wa);
            access(1, 0, 5'h19, 8'h33, tb, wb);
        join
        chk(tb - ta == 3, "fixed_priority_order", tb - ta, 3);

        // Reset in the middle of a CPU read abandons it silently
        @(negedge clk);
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h07; cpu_wdata = 8'h5A;
        @(negedge clk);
        chk(mem_rd && busy, "issue_before_reset", {mem_rd, busy}, 2'b11);
        rst = 1;
        cpu_req = 0;
        kc = cpu_n;
        @(negedge clk);
        chk({cpu_ack, dbg_ack, mem_rd, mem_wr, busy, mem_addr, mem_wdata, cpu_rdata, dbg_rdata} == 0,
            "mid_reset_state", {cpu_ack, dbg_ack, mem_rd, mem_wr, busy, mem_addr}, 0);
        rst = 0;
        repeat (8) @(negedge clk);
        chk(cpu_n == kc, "abandoned_no_ack", cpu_n - kc, 0);

        // CPU holds req continuously while debug waits
        ec.wr = 0; ec.addr = 5'h02; ec.wdata = 8'h44; ec.rdata = ref_mem[2];
        ed.wr = 0; ed.addr = 5'h14; ed.wdata = 8'h55; ed.rdata = ref_mem[20];
        @(negedge clk);
        cpu_req = 1; cpu_wr = 0; cpu_addr = ec.addr; cpu_wdata = ec.wdata;
        dbg_req = 1; dbg_wr = 0; dbg_addr = ed.addr; dbg_wdata = ed.wdata;
        exp_cpu.push_back(ec);
        exp_dbg.push_back(ed);
        kc = 0; kd_at = -1; cyc_d = 0; cpu_after = -1; cpu_on = 1; dbg_on = 1;
        for (int i = 0; i < 200 && (cpu_on || dbg_on); i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                kc++;
                if (kd_at >= 0 && cpu_after < 0) cpu_after = cyc - cyc_d;
                if (kc < 10) exp_cpu.push_back(ec);
                else begin cpu_req = 0; cpu_on = 0; end
            end
            if (dbg_ack) begin
                kd_at = kc; cyc_d = cyc; dbg_req = 0; dbg_on = 0;
            end
        end
        chk(!cpu_on && !dbg_on, "hold_timeout", {cpu_on, dbg_on}, 0);
`ifdef ARB_STARVE_GUARD_EN
        chk(kd_at == 4, "starve_guard_grant", kd_at, 4);
        chk(cpu_after == 3, "cpu_after_guard", cpu_after, 3);
`else
        chk(kd_at == 10, "strict_cpu_priority", kd_at, 10);
`endif

        // Random concurrent traffic; ports use disjoint halves so order across ports is irrelevant
        fork
            for (int i = 0; i < 30; i++) begin
                int t0, w0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                access(0, 1'($urandom), 5'($urandom_range(0, 15)), 8'($urandom), t0, w0);
            end
            for (int i = 0; i < 30; i++) begin
                int t1, w1;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                access(1, 1'($urandom), 5'($urandom_range(16, 31)), 8'($urandom), t1, w1);
            end
        join
        repeat (4) @(negedge clk);
        chk(exp_cpu.size() == 0 && exp_dbg.size() == 0, "queues_drained", exp_cpu.size() + exp_dbg.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
